// File: rtl/led_sequence_ctrl.sv
// Button-driven 4-LED sequencer: rotate left/right, bounce and blink at four speeds, with pause.
// Define LED_CTRL_DEBOUNCE_EN to include the per-button debouncer; otherwise synchronized levels feed the edge detector.
module led_sequence_ctrl #(
    parameter logic [31:0] TICK_BASE = 32'd100000000,
    parameter logic [19:0] DEB_CYC   = 20'd1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_speed,
    input  logic       btn_pause,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic [1:0] speed,
    output logic       paused,
    output logic       step
);
    typedef enum logic [1:0] {
        ROT_L  = 2'd0,
        ROT_R  = 2'd1,
        BOUNCE = 2'd2,
        BLINK  = 2'd3
    } mode_e;

    function automatic logic [3:0] init_pattern(input mode_e m);
        case (m)
            ROT_L:   init_pattern = 4'b0001;
            ROT_R:   init_pattern = 4'b1000;
            BOUNCE:  init_pattern = 4'b0001;
            default: init_pattern = 4'b1111;
        endcase
    endfunction

    // Returns {dir, led}; dir 0 means the bounce is travelling towards bit 3.
    function automatic logic [4:0] advance(input mode_e m, input logic dir, input logic [3:0] l);
        case (m)
            ROT_L:   advance = {dir, l[2:0], l[3]};
            ROT_R:   advance = {dir, l[0], l[3:1]};
            BOUNCE: begin
                if (!dir)
                    advance = (l == 4'b1000) ? {1'b1, 4'b0100} : {1'b0, l[2:0], 1'b0};
                else
                    advance = (l == 4'b0001) ? {1'b0, 4'b0010} : {1'b1, 1'b0, l[3:1]};
            end
            default: advance = {dir, ~l};
        endcase
    endfunction

    // Bit order for all per-button vectors: [0] mode, [1] speed, [2] pause.
    logic [2:0] btn_raw;
    logic [2:0] sync0_q;
    logic [2:0] sync1_q;
    logic [2:0] lvl;
    logic [2:0] lvl_prev_q;
    logic [2:0] cmd_q;

    assign btn_raw = {btn_pause, btn_speed, btn_mode};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync0_q    <= '0;
            sync1_q    <= '0;
            lvl_prev_q <= '0;
            cmd_q      <= '0;
        end else begin
            sync0_q    <= btn_raw;
            sync1_q    <= sync0_q;
            lvl_prev_q <= lvl;
            cmd_q      <= lvl & ~lvl_prev_q;
        end
    end

`ifdef LED_CTRL_DEBOUNCE_EN
    logic [2:0]       acc_q;
    logic [2:0]       acc_d;
    logic [2:0][19:0] deb_cnt_q;
    logic [2:0][19:0] deb_cnt_d;

    always_comb begin
        acc_d     = acc_q;
        deb_cnt_d = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync1_q[i] != acc_q[i]) begin
                if (deb_cnt_q[i] + 20'd1 >= DEB_CYC)
                    acc_d[i] = sync1_q[i];
                else
                    deb_cnt_d[i] = deb_cnt_q[i] + 20'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            deb_cnt_q <= '0;
        end else begin
            acc_q     <= acc_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign lvl = acc_q;
`else
    logic unused_deb_cyc;
    assign unused_deb_cyc = ^DEB_CYC;
    assign lvl = sync1_q;
`endif

    logic [31:0] period;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  led_q, led_d;
    mode_e       mode_q, mode_d;
    logic [1:0]  speed_q, speed_d;
    logic        paused_q, paused_d;
    logic        dir_q, dir_d;
    logic        any_cmd;
    logic        tc;

    assign period  = TICK_BASE >> speed_q;
    assign any_cmd = |cmd_q;
    assign tc      = !paused_q && (cnt_q == period - 32'd1);

    // Any command in a cycle suppresses that cycle's step, so loads and clears always win.
    always_comb begin
        mode_d   = mode_q;
        speed_d  = speed_q;
        paused_d = paused_q ^ cmd_q[2];
        cnt_d    = cnt_q;
        led_d    = led_q;
        dir_d    = dir_q;
        step     = 1'b0;
        if (cmd_q[0]) begin
            mode_d = mode_e'(mode_q + 2'd1);
            led_d  = init_pattern(mode_d);
            dir_d  = 1'b0;
            cnt_d  = '0;
        end
        if (cmd_q[1]) begin
            speed_d = speed_q + 2'd1;
            cnt_d   = '0;
        end
        if (!any_cmd && !paused_q) begin
            if (tc) begin
                cnt_d          = '0;
                step           = 1'b1;
                {dir_d, led_d} = advance(mode_q, dir_q, led_q);
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            led_q    <= 4'b0001;
            mode_q   <= ROT_L;
            speed_q  <= '0;
            paused_q <= 1'b0;
            dir_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            led_q    <= led_d;
            mode_q   <= mode_d;
            speed_q  <= speed_d;
            paused_q <= paused_d;
            dir_q    <= dir_d;
        end
    end

    assign led    = led_q;
    assign mode   = mode_q;
    assign speed  = speed_q;
    assign paused = paused_q;
endmodule
